// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode stage: PC, req/ack instruction fetch,
// instruction register and MIPS field split.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        advance,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [25:0] target,
  output logic [15:0] instr_count,
  output logic        fetch_err
);

  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          wait_d  = '0;
          state_d = VALID;
        end else if (wait_q == WMAX) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      VALID: begin
        // a misaligned branch target faults without retiring
        if (advance) begin
          if (branch_en && (branch_target[1:0] != 2'b00)) begin
            state_d = ERROR;
          end else begin
            pc_d    = branch_en ? branch_target : pc_q + 32'd4;
            cnt_d   = cnt_q + 16'd1;
            state_d = FETCH;
          end
        end
      end
      ERROR: state_d = ERROR;
    endcase
  end

  assign mem_req     = (state_q == FETCH);
  assign instr_valid = (state_q == VALID);
  assign fetch_err   = (state_q == ERROR);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign target = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: fetched words are queued
// on ack and compared against the decoded fields when valid rises.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        advance = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic [15:0] instr_count;
  logic        fetch_err;

  instr_fetch_decode #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .advance      (advance),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .funct        (funct),
    .imm          (imm),
    .target       (target),
    .instr_count  (instr_count),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_err;
  logic        pv = 1'b0;
  logic [31:0] sext;

  // downstream registered sign extender
  always_ff @(posedge clk) sext <= {{16{imm[15]}}, imm};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && !pv) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_fields", {opcode, rs, rt, rd, shamt, funct}, e.w);
        chk("sb_imm", {16'h0, imm}, {16'h0, e.w[15:0]});
        chk("sb_target", {6'h0, target}, {6'h0, e.w[25:0]});
      end
    end
    pv = instr_valid;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_vld"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_err"}, {31'h0, fetch_err}, 32'h0);
    chk({tag, "_cnt"}, {16'h0, instr_count}, 32'h0);
    chk({tag, "_ir"}, {opcode, rs, rt, rd, shamt, funct}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    advance = 1'b0;
    branch_en = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    m_pc = 32'h0;
    m_cnt = 16'h0;
    m_err = 1'b0;
    @(negedge clk);
    chk("req_rise", {31'h0, mem_req}, 32'h1);
  endtask

  task automatic fetch(input logic [31:0] w, input int dly);
    for (int i = 0; i < 8 && !mem_req; i++) @(negedge clk);
    chk("req_seen", {31'h0, mem_req}, 32'h1);
    chk("mem_addr", mem_addr, m_pc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_hold", {31'h0, mem_req}, 32'h1);
    end
    mem_ack = 1'b1;
    mem_rdata = w;
    sb.push_back('{pc: m_pc, w: w});
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic adv(input logic br, input logic [31:0] tgt,
                     input logic with_ack);
    chk("adv_pre", {31'h0, instr_valid}, 32'h1);
    advance = 1'b1;
    branch_en = br;
    branch_target = tgt;
    mem_ack = with_ack;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    advance = 1'b0;
    branch_en = 1'b0;
    mem_ack = 1'b0;
    if (br && tgt[1:0] != 2'b00) begin
      m_err = 1'b1;
    end else begin
      m_pc = br ? tgt : m_pc + 32'd4;
      m_cnt = m_cnt + 16'd1;
    end
    chk("adv_pc", pc, m_pc);
    chk("adv_cnt", {16'h0, instr_count}, {16'h0, m_cnt});
    chk("adv_err", {31'h0, fetch_err}, {31'h0, m_err});
    chk("adv_req", {31'h0, mem_req}, {31'h0, ~m_err});
  endtask

  initial begin
    int n;
    m_pc = 32'h0;
    m_cnt = 16'h0;
    m_err = 1'b0;
    do_reset();

    fetch(32'h2008_FFE2, 0);
    chk("addi_op", {26'h0, opcode}, 32'h08);
    chk("addi_rs", {27'h0, rs}, 32'h0);
    chk("addi_rt", {27'h0, rt}, 32'h8);
    chk("addi_imm", {16'h0, imm}, 32'hFFE2);
    @(negedge clk);
    chk("sext", sext, 32'hFFFF_FFE2);

    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ackv_ir", {opcode, rs, rt, rd, shamt, funct}, 32'h2008_FFE2);
    chk("ackv_vld", {31'h0, instr_valid}, 32'h1);
    chk("ackv_req", {31'h0, mem_req}, 32'h0);

    adv(1'b0, 32'h0, 1'b0);
    fetch(32'h014B_4820, 0);
    adv(1'b0, 32'h0, 1'b0);
    fetch(32'h8D2A_0004, 2);
    adv(1'b0, 32'h0, 1'b0);
    chk("cnt3", {16'h0, instr_count}, 32'd3);

    fetch(32'h1000_000F, 0);
    adv(1'b1, 32'h0000_0040, 1'b1);
    fetch(32'hAC0B_0010, 0);

    dut.cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    adv(1'b0, 32'h0, 1'b0);
    chk("cnt_wrap", {16'h0, instr_count}, 32'h0);

    fetch(32'h3C01_ABCD, 1);
    adv(1'b1, 32'h0000_0042, 1'b0);
    advance = 1'b1;
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    advance = 1'b0;
    mem_ack = 1'b0;
    chk("err_stay", {31'h0, fetch_err}, 32'h1);
    chk("err_pc", pc, 32'h0000_0044);
    chk("err_vld", {31'h0, instr_valid}, 32'h0);

    do_reset();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd16);
    chk("to_err", {31'h0, fetch_err}, 32'h1);
    chk("to_req", {31'h0, mem_req}, 32'h0);

    do_reset();
    fetch(32'h2129_7FFF, 0);
    adv(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("f3_req", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("sb_left", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
